cpu_step_ctrl: RTL

//  Run/step/breakpoint sequencer that generates the clock-enable for the on-board MIPS core.

---
 rtl/dbg_pkg.sv | 18 +
 rtl/btn_debounce.sv | 58 +++++
 rtl/cpu_step_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared debug/step types and board-rate defaults for the MIPS step controller.
package dbg_pkg;

  // Sequencer state, also exported to the 7-seg/UART debug path.
  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    BRK  = 2'd3
  } step_state_t;

  // Board rates for a 100 MHz system clock.
  localparam int unsigned DIV_SLOW_DEF   = 250_000_000;  // ~0.4 Hz step rate
  localparam int unsigned DIV_FAST_DEF   = 62_500_000;   // ~1.6 Hz step rate
  localparam int unsigned DEB_CYCLES_DEF = 1_000_000;    // 10 ms button settle time
  localparam int unsigned CNT_W_DEF      = 16;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-sample debouncer and a
// one-cycle pulse on each rising edge of the accepted level.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          pulse_q, pulse_d;

  // Next-state: count consecutive samples that disagree with the accepted level.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint sequencer producing the registered clock-enable for the
// MIPS core, plus state and issued-step count for the debug display.
module cpu_step_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned DIV_SLOW   = DIV_SLOW_DEF,
  parameter int unsigned DIV_FAST   = DIV_FAST_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             CLK100MHZ,
  input  logic             rst_n,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             quick,
  input  logic             bp_en,
  input  logic [7:0]       bp_addr,
  input  logic [7:0]       pclow,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int unsigned DIV_W   = $clog2(DIV_MAX);

  logic [DIV_W-1:0] div_q, div_d, div_lim;
  logic             tick;
  logic             step_pulse;
  logic             issue;
  step_state_t      state_q, state_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_step_deb (
    .clk     (CLK100MHZ),
    .rst_n   (rst_n),
    .btn_raw (step_btn),
    .pulse   (step_pulse)
  );

  // Step-rate divider; >= lets a mid-count switch to the fast rate fire immediately.
  always_comb begin
    div_lim = quick ? DIV_W'(DIV_FAST - 1) : DIV_W'(DIV_SLOW - 1);
    tick    = (div_q >= div_lim);
    div_d   = tick ? '0 : div_q + 1'b1;
  end

  // Sequencer next state and issue decision.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      HALT: begin
        if (run_sw)          state_d = RUN;
        else if (step_pulse) state_d = STEP;
      end
      RUN: begin
        if (!run_sw)                            state_d = HALT;
        else if (tick && bp_en && pclow == bp_addr) state_d = BRK;
        else if (tick)                          issue   = 1'b1;
      end
      STEP: begin
        // Breakpoint is not checked here so the core can step off it.
        if (tick) begin
          issue   = 1'b1;
          state_d = HALT;
        end
      end
      BRK: begin
        if (!run_sw)         state_d = HALT;
        else if (step_pulse) state_d = STEP;
      end
      default: state_d = HALT;
    endcase
  end

  // Output register and step counter advance together with the issue.
  always_comb begin
    cpu_ce_d   = issue;
    step_cnt_d = step_cnt_q + CNT_W'(issue);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      div_q      <= '0;
      state_q    <= HALT;
      cpu_ce_q   <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      div_q      <= div_d;
      state_q    <= state_d;
      cpu_ce_q   <= cpu_ce_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign cpu_ce   = cpu_ce_q;
  assign state    = state_q;
  assign step_cnt = step_cnt_q;

endmodule
